// File: rtl/rsa_header_streamer.sv
// rsa_header_streamer: buffers encrypted RSA headers and streams them as WORD_W-bit words
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   header_i, header_valid_i   header from the RSA core, one-cycle done pulse
//   word_o, word_valid_o,
//   word_ready_i, last_o       valid/ready word stream, last_o marks a header's final word
//   busy_o                     active or pending slot occupied
//   overflow_o, clr_ovf_i      sticky dropped-header flag and its synchronous clear
module rsa_header_streamer #(
  parameter int HDR_W = 128,
  parameter int WORD_W = 32,
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HDR_W-1:0]  header_i,
  input  logic              header_valid_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              last_o,
  output logic              busy_o,
  output logic              overflow_o,
  input  logic              clr_ovf_i
);
  localparam int N = HDR_W / WORD_W;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [HDR_W-1:0] act, pend;
  logic pend_v;
  logic [CW-1:0] cnt;
  logic fire, done, hold_new;
  assign word_valid_o = state == SEND;
  assign last_o = word_valid_o & (cnt == CW'(N - 1));
  assign word_o = MSW_FIRST ? act[HDR_W-1 -: WORD_W] : act[WORD_W-1:0];
  assign busy_o = word_valid_o | pend_v;
  assign fire = word_valid_o & word_ready_i;
  assign done = fire & last_o;
  // a new header must wait in (or be dropped from) pending when the active slot stays occupied
  assign hold_new = header_valid_i & word_valid_o & ~done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      act <= '0;
      pend <= '0;
      pend_v <= 1'b0;
      cnt <= '0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= (hold_new & pend_v) | (overflow_o & ~clr_ovf_i);
      if (hold_new & ~pend_v) begin
        pend <= header_i;
        pend_v <= 1'b1;
      end
      if (state == IDLE) begin
        if (header_valid_i) begin
          act <= header_i;
          cnt <= '0;
          state <= SEND;
        end
      end else if (done) begin
        cnt <= '0;
        if (pend_v) begin
          // pending moves up; a same-cycle arrival takes its place
          act <= pend;
          pend <= header_i;
          pend_v <= header_valid_i;
        end else if (header_valid_i) begin
          act <= header_i;
        end else begin
          act <= '0;
          state <= IDLE;
        end
      end else if (fire) begin
        cnt <= cnt + CW'(1);
        act <= MSW_FIRST ? act << WORD_W : act >> WORD_W;
      end
    end
  end
endmodule

// File: tb/tb_rsa_header_streamer.sv
// tb_rsa_header_streamer: table-driven and directed checks of rsa_header_streamer
module tb_rsa_header_streamer;
  logic clk = 1'b0;
  logic rst_n;
  logic [127:0] header_i;
  logic header_valid_i, word_ready_i, clr_ovf_i;
  logic [31:0] word_o, word_l;
  logic word_valid_o, last_o, busy_o, overflow_o;
  logic valid_l, last_l, busy_l, ovf_l;
  int checks = 0;
  int errors = 0;

  localparam logic [127:0] HA = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] HB = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] HC = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;

  always #5 clk = ~clk;

  rsa_header_streamer #(.HDR_W(128), .WORD_W(32), .MSW_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .header_i(header_i), .header_valid_i(header_valid_i),
    .word_o(word_o), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .last_o(last_o), .busy_o(busy_o), .overflow_o(overflow_o), .clr_ovf_i(clr_ovf_i));

  rsa_header_streamer #(.HDR_W(128), .WORD_W(32), .MSW_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .header_i(header_i), .header_valid_i(header_valid_i),
    .word_o(word_l), .word_valid_o(valid_l), .word_ready_i(word_ready_i),
    .last_o(last_l), .busy_o(busy_l), .overflow_o(ovf_l), .clr_ovf_i(clr_ovf_i));

  typedef struct {
    logic hv;
    logic [127:0] hdr;
    logic rdy;
    logic clr;
    logic ev;
    logic [31:0] ew;
    logic el;
    logic eb;
    logic eo;
  } vec_t;
  vec_t vq[$];

  function automatic void add(input logic hv, input logic [127:0] hdr, input logic rdy,
                              input logic clr, input logic ev, input logic [31:0] ew,
                              input logic el, input logic eb, input logic eo);
    vq.push_back('{hv: hv, hdr: hdr, rdy: rdy, clr: clr, ev: ev, ew: ew, el: el, eb: eb, eo: eo});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic hv, input logic [127:0] hdr, input logic rdy, input logic clr);
    @(negedge clk);
    header_valid_i = hv;
    header_i = hdr;
    word_ready_i = rdy;
    clr_ovf_i = clr;
    #1;
  endtask

  task automatic idle_row(input logic rdy, input logic clr, input logic eo);
    add(1'b0, '0, rdy, clr, 1'b0, '0, 1'b0, 1'b0, eo);
  endtask

  task automatic w(input logic hv, input logic [127:0] hdr, input logic rdy,
                   input logic [31:0] ew, input logic el, input logic eo);
    add(hv, hdr, rdy, 1'b0, 1'b1, ew, el, 1'b1, eo);
  endtask

  initial begin
    rst_n = 1'b0;
    header_i = '0;
    header_valid_i = 1'b0;
    word_ready_i = 1'b0;
    clr_ovf_i = 1'b0;
    #1;
    chk("reset_word", word_o, 32'h0);
    chk("reset_valid", {31'b0, word_valid_o}, 32'h0);
    chk("reset_last", {31'b0, last_o}, 32'h0);
    chk("reset_busy", {31'b0, busy_o}, 32'h0);
    chk("reset_ovf", {31'b0, overflow_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single header
    add(1'b1, HA, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    w(0, '0, 1, 32'h00112233, 0, 0);
    w(0, '0, 1, 32'h44556677, 0, 0);
    w(0, '0, 1, 32'h8899AABB, 0, 0);
    w(0, '0, 1, 32'hCCDDEEFF, 1, 0);
    idle_row(1, 0, 0);
    // backpressure on words 2..4
    add(1'b1, HA, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    w(0, '0, 1, 32'h00112233, 0, 0);
    w(0, '0, 0, 32'h44556677, 0, 0);
    w(0, '0, 0, 32'h44556677, 0, 0);
    w(0, '0, 0, 32'h44556677, 0, 0);
    w(0, '0, 1, 32'h44556677, 0, 0);
    w(0, '0, 1, 32'h8899AABB, 0, 0);
    w(0, '0, 1, 32'hCCDDEEFF, 1, 0);
    idle_row(1, 0, 0);
    // back-to-back via pending
    add(1'b1, HA, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    w(0, '0, 1, 32'h00112233, 0, 0);
    w(1, HB, 1, 32'h44556677, 0, 0);
    w(0, '0, 1, 32'h8899AABB, 0, 0);
    w(0, '0, 1, 32'hCCDDEEFF, 1, 0);
    w(0, '0, 1, 32'h01020304, 0, 0);
    w(0, '0, 1, 32'h05060708, 0, 0);
    w(0, '0, 1, 32'h090A0B0C, 0, 0);
    w(0, '0, 1, 32'h0D0E0F10, 1, 0);
    idle_row(1, 0, 0);
    // overflow: third header dropped while stalled
    add(1'b1, HA, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    w(1, HB, 0, 32'h00112233, 0, 0);
    w(1, HC, 0, 32'h00112233, 0, 0);
    w(0, '0, 1, 32'h00112233, 0, 1);
    w(0, '0, 1, 32'h44556677, 0, 1);
    w(0, '0, 1, 32'h8899AABB, 0, 1);
    w(0, '0, 1, 32'hCCDDEEFF, 1, 1);
    w(0, '0, 1, 32'h01020304, 0, 1);
    w(0, '0, 1, 32'h05060708, 0, 1);
    w(0, '0, 1, 32'h090A0B0C, 0, 1);
    w(0, '0, 1, 32'h0D0E0F10, 1, 1);
    idle_row(1, 1, 1);
    idle_row(1, 0, 0);
    // new header on last handshake with pending empty loads active directly
    add(1'b1, HA, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    w(0, '0, 1, 32'h00112233, 0, 0);
    w(0, '0, 1, 32'h44556677, 0, 0);
    w(0, '0, 1, 32'h8899AABB, 0, 0);
    w(1, HB, 1, 32'hCCDDEEFF, 1, 0);
    w(0, '0, 1, 32'h01020304, 0, 0);
    w(0, '0, 1, 32'h05060708, 0, 0);
    w(0, '0, 1, 32'h090A0B0C, 0, 0);
    w(0, '0, 1, 32'h0D0E0F10, 1, 0);
    idle_row(1, 0, 0);
    // new header while pending moves up goes into pending, no drop
    add(1'b1, HA, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    w(1, HB, 1, 32'h00112233, 0, 0);
    w(0, '0, 1, 32'h44556677, 0, 0);
    w(0, '0, 1, 32'h8899AABB, 0, 0);
    w(1, HC, 1, 32'hCCDDEEFF, 1, 0);
    w(0, '0, 1, 32'h01020304, 0, 0);
    w(0, '0, 1, 32'h05060708, 0, 0);
    w(0, '0, 1, 32'h090A0B0C, 0, 0);
    w(0, '0, 1, 32'h0D0E0F10, 1, 0);
    w(0, '0, 1, 32'hC0C1C2C3, 0, 0);
    w(0, '0, 1, 32'hC4C5C6C7, 0, 0);
    w(0, '0, 1, 32'hC8C9CACB, 0, 0);
    w(0, '0, 1, 32'hCCCDCECF, 1, 0);
    idle_row(1, 0, 0);
    // clear and drop in the same cycle: drop wins
    add(1'b1, HA, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    w(1, HB, 0, 32'h00112233, 0, 0);
    w(1, HC, 0, 32'h00112233, 0, 0);
    add(1'b1, HC, 1'b0, 1'b1, 1'b1, 32'h00112233, 1'b0, 1'b1, 1'b1);
    w(0, '0, 0, 32'h00112233, 0, 1);
    add(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h00112233, 1'b0, 1'b1, 1'b1);
    w(0, '0, 1, 32'h00112233, 0, 0);
    w(0, '0, 1, 32'h44556677, 0, 0);
    w(0, '0, 1, 32'h8899AABB, 0, 0);
    w(0, '0, 1, 32'hCCDDEEFF, 1, 0);
    w(0, '0, 1, 32'h01020304, 0, 0);
    w(0, '0, 1, 32'h05060708, 0, 0);
    w(0, '0, 1, 32'h090A0B0C, 0, 0);
    w(0, '0, 1, 32'h0D0E0F10, 1, 0);
    idle_row(1, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].hv, vq[i].hdr, vq[i].rdy, vq[i].clr);
      chk($sformatf("row%0d_valid", i), {31'b0, word_valid_o}, {31'b0, vq[i].ev});
      if (vq[i].ev) chk($sformatf("row%0d_word", i), word_o, vq[i].ew);
      chk($sformatf("row%0d_last", i), {31'b0, last_o}, {31'b0, vq[i].el});
      chk($sformatf("row%0d_busy", i), {31'b0, busy_o}, {31'b0, vq[i].eb});
      chk($sformatf("row%0d_ovf", i), {31'b0, overflow_o}, {31'b0, vq[i].eo});
    end

    // reset in the middle of a header
    drive(1, HA, 1, 0);
    drive(0, '0, 1, 0);
    chk("rst_pre_word0", word_o, 32'h00112233);
    drive(0, '0, 1, 0);
    chk("rst_pre_word1", word_o, 32'h44556677);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_word", word_o, 32'h0);
    chk("rst_mid_valid", {31'b0, word_valid_o}, 32'h0);
    chk("rst_mid_last", {31'b0, last_o}, 32'h0);
    chk("rst_mid_busy", {31'b0, busy_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(0, '0, 1, 0);
      chk($sformatf("rst_after_valid%0d", k), {31'b0, word_valid_o}, 32'h0);
      chk($sformatf("rst_after_busy%0d", k), {31'b0, busy_o}, 32'h0);
    end
    drive(1, HB, 1, 0);
    drive(0, '0, 1, 0);
    chk("rst_new_w0", word_o, 32'h01020304);
    chk("rst_new_v0", {31'b0, word_valid_o}, 32'h1);
    drive(0, '0, 1, 0);
    chk("rst_new_w1", word_o, 32'h05060708);
    drive(0, '0, 1, 0);
    chk("rst_new_w2", word_o, 32'h090A0B0C);
    drive(0, '0, 1, 0);
    chk("rst_new_w3", word_o, 32'h0D0E0F10);
    chk("rst_new_last", {31'b0, last_o}, 32'h1);
    drive(0, '0, 1, 0);
    chk("rst_new_idle", {31'b0, word_valid_o}, 32'h0);

    // least-significant-word-first instance
    drive(1, HA, 1, 0);
    chk("lsw_idle", {31'b0, valid_l}, 32'h0);
    drive(0, '0, 1, 0);
    chk("lsw_w0", word_l, 32'hCCDDEEFF);
    chk("lsw_v0", {31'b0, valid_l}, 32'h1);
    chk("lsw_l0", {31'b0, last_l}, 32'h0);
    drive(0, '0, 1, 0);
    chk("lsw_w1", word_l, 32'h8899AABB);
    drive(0, '0, 1, 0);
    chk("lsw_w2", word_l, 32'h44556677);
    drive(0, '0, 1, 0);
    chk("lsw_w3", word_l, 32'h00112233);
    chk("lsw_l3", {31'b0, last_l}, 32'h1);
    drive(0, '0, 1, 0);
    chk("lsw_done_valid", {31'b0, valid_l}, 32'h0);
    chk("lsw_done_busy", {31'b0, busy_l}, 32'h0);
    chk("lsw_ovf", {31'b0, ovf_l}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
